controle_exibe_sequencia: RTL and testbench
===========================================

# controle_exibe_sequencia

Playback sequencer for the memory game: on request, walks the sequence memory from address 0 to a latched last address. Each stored value is shown on the LEDs for a fixed on-time, followed by a fixed off-time. It drives the memory address and LED enable of the game datapath and sits beside the main game controller, which starts it before each player round and waits for `fim`.

## Interface
Parameters:
- `ADDR_W`, 4: memory address width.
- `T_ON`, 1000: cycles the LEDs are lit per element (≥1).
- `T_OFF`, 500: cycles the LEDs are dark after each element (≥1).

Ports:
- `clock` in 1: single system clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `iniciar` in 1: start request, sampled only in OCIOSO.
- `limite` in ADDR_W: index of the last element to show (sequence length − 1), latched at start.
- `abortar` in 1: synchronous cancel.
- `endereco` out ADDR_W: address to the sequence memory.
- `leds_en` out 1: gates memory data onto the LEDs.
- `ocupado` out 1: high in every state except OCIOSO.
- `fim` out 1: one-cycle pulse when playback completes normally.
- `db_estado` out 4: state code for the debug display.

## Operation
- States and codes: OCIOSO=0, CARREGA=1, ACESO=2, APAGADO=3, FIM=4. Codes 5–15 are unused; any unused code goes to OCIOSO.
- OCIOSO:
  - `endereco`=0.
  - `iniciar`=1 → latch `limite` into `lim_r`, load the timer, go to CARREGA.
- CARREGA: one cycle, covering the synchronous memory read latency. Load the timer with T_ON−1, go to ACESO.
- ACESO:
  - `leds_en`=1.
  - Timer counts down; at 0 load T_OFF−1 and go to APAGADO.
- APAGADO: `leds_en`=0. At timer 0:
  - if `endereco`==`lim_r` → FIM;
  - else `endereco`++ → CARREGA.
- FIM: `fim`=1 for exactly one cycle, `endereco` cleared, → OCIOSO.
- Boundary conditions:
  - `abortar`=1 in any state other than OCIOSO → OCIOSO next cycle. `endereco` is cleared, no `fim` pulse. `abortar` has priority over every other transition.
  - `iniciar` while `ocupado` is ignored.
  - `iniciar` and `abortar` together in OCIOSO: `abortar` wins, stay in OCIOSO.
  - `limite` changes mid-playback have no effect; only `lim_r` is used.
  - `lim_r`=2^ADDR_W−1: all 2^ADDR_W elements are shown. `endereco` never wraps, because the compare fires before the increment.
  - `lim_r`=0: a single element is shown.
- Width rule: the timer is `$clog2(max(T_ON,T_OFF))` bits and unsigned. The address compare is an ADDR_W-bit equality.

## Timing
- Reset values (asynchronous, on `reset`=0):
  - state OCIOSO, `endereco`=0, `lim_r`=0, timer 0;
  - `leds_en`=0, `ocupado`=0, `fim`=0, `db_estado`=0.
- All outputs are decoded from registers (Moore), so there is no combinational path from inputs to outputs.
- `iniciar` sampled at edge k:
  - CARREGA during cycle k+1;
  - `leds_en` high for cycles k+2 .. k+1+T_ON;
  - element period is 1+T_ON+T_OFF cycles.
- For N = `lim_r`+1 elements, `fim` is high during cycle k+1+N·(1+T_ON+T_OFF). `ocupado` falls the next cycle.
- `endereco` changes only on the CARREGA entry edge, so it is stable for the whole of its CARREGA/ACESO/APAGADO window.
- A new `iniciar` is accepted at the earliest in the cycle after FIM.

## Structure
- Shared package `genius_pkg` holds:
  - the state encoding localparams (OCIOSO..FIM, 4-bit) reused by the `db_estado` hex display;
  - the default T_ON/T_OFF constants.
- One natural sub-module, `contador_tempo`:
  - parameterized down-counter with synchronous load value, enable and `zero` flag;
  - instantiated once and shared by ACESO and APAGADO.
- Address register and `lim_r` live in the FSM module. No further hierarchy.

## Test plan
All scenarios use T_ON=3, T_OFF=2, ADDR_W=4.
1. Reset mid-ACESO: drive `reset`=0 asynchronously → all outputs are 0 immediately; state stays OCIOSO after release.
2. `limite`=0, `iniciar` at edge k → `leds_en` high for cycles k+2..k+4 with `endereco`=0; `fim` at k+7 only; `ocupado` high for k+1..k+7.
3. `limite`=2 → `endereco` steps 0,1,2 at k+1, k+7, k+13; three `leds_en` bursts of 3 cycles each; `fim` at k+19; `limite` changed to 5 at k+4 has no effect.
4. `limite`=15 → 16 bursts; last `endereco`=15, no wrap to 0 before FIM; `fim` at k+1+16·6 = k+97.
5. `abortar` asserted during the second APAGADO of `limite`=3 → OCIOSO next cycle, `endereco`=0, `fim` never pulses; a following `iniciar` restarts from address 0.
6. `iniciar` re-pulsed while `ocupado`, and `iniciar`+`abortar` together in OCIOSO → both ignored; the running sequence timing matches scenario 3 exactly.

Source files
------------

// File: rtl/genius_pkg.sv
// Shared constants for the memory-game controllers: state codes and playback timing.
// Latency: none (declarations only).
// Backpressure: not applicable.
package genius_pkg;

    // State codes, also shown as-is on the db_estado hex display.
    localparam logic [3:0] COD_OCIOSO  = 4'd0;
    localparam logic [3:0] COD_CARREGA = 4'd1;
    localparam logic [3:0] COD_ACESO   = 4'd2;
    localparam logic [3:0] COD_APAGADO = 4'd3;
    localparam logic [3:0] COD_FIM     = 4'd4;

    typedef enum logic [3:0] {
        OCIOSO  = COD_OCIOSO,
        CARREGA = COD_CARREGA,
        ACESO   = COD_ACESO,
        APAGADO = COD_APAGADO,
        FIM     = COD_FIM
    } estado_t;

    // Default LED on/off times in clock cycles.
    localparam int T_ON_PADRAO  = 1000;
    localparam int T_OFF_PADRAO = 500;

endpackage

// File: rtl/contador_tempo.sv
// Down-counter with synchronous load, count enable and a zero flag.
// Latency: load/decrement visible one cycle after the edge; zero is decoded from the register.
// Backpressure: none; holds at zero until reloaded.
module contador_tempo #(
    parameter int W = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         carrega,
    input  logic         habilita,
    input  logic [W-1:0] valor,
    output logic         zero
);

    logic [W-1:0] contagem;

    // Load has priority over counting; counting stops at zero.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            contagem <= '0;
        end else if (carrega) begin
            contagem <= valor;
        end else if (habilita && (contagem != '0)) begin
            contagem <= contagem - W'(1);
        end
    end

    assign zero = (contagem == '0);

endmodule

// File: rtl/controle_exibe_sequencia.sv
// Playback sequencer: shows memory entries 0..lim_r on the LEDs, T_ON cycles lit then T_OFF dark each.
// Latency: first element lit two cycles after iniciar; fim at 1 + N*(1+T_ON+T_OFF) cycles.
// Backpressure: iniciar ignored while ocupado; abortar cancels at any time without fim.
module controle_exibe_sequencia
    import genius_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int T_ON   = T_ON_PADRAO,
    parameter int T_OFF  = T_OFF_PADRAO
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              iniciar,
    input  logic [ADDR_W-1:0] limite,
    input  logic              abortar,
    output logic [ADDR_W-1:0] endereco,
    output logic              leds_en,
    output logic              ocupado,
    output logic              fim,
    output logic [3:0]        db_estado
);

    localparam int T_MAX = (T_ON > T_OFF) ? T_ON : T_OFF;
    localparam int TW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;
    localparam logic [TW-1:0] CARGA_ON  = TW'(T_ON - 1);
    localparam logic [TW-1:0] CARGA_OFF = TW'(T_OFF - 1);

    estado_t           estado, prox_estado;
    logic [ADDR_W-1:0] lim_r;
    logic              tmr_carrega, tmr_habilita, tmr_zero;
    logic [TW-1:0]     tmr_valor;
    logic              end_limpa, end_incrementa, lim_carrega;

    // Single timer shared by the lit and dark phases.
    contador_tempo #(.W(TW)) u_tempo (
        .clock    (clock),
        .reset    (reset),
        .carrega  (tmr_carrega),
        .habilita (tmr_habilita),
        .valor    (tmr_valor),
        .zero     (tmr_zero)
    );

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado <= OCIOSO;
        end else begin
            estado <= prox_estado;
        end
    end

    // Next state and datapath controls; abortar overrides every transition.
    always_comb begin
        prox_estado    = estado;
        tmr_carrega    = 1'b0;
        tmr_habilita   = 1'b0;
        tmr_valor      = CARGA_ON;
        end_limpa      = 1'b0;
        end_incrementa = 1'b0;
        lim_carrega    = 1'b0;
        if (abortar) begin
            prox_estado = OCIOSO;
            end_limpa   = 1'b1;
        end else begin
            case (estado)
                OCIOSO: begin
                    if (iniciar) begin
                        lim_carrega = 1'b1;
                        tmr_carrega = 1'b1;
                        prox_estado = CARREGA;
                    end
                end
                CARREGA: begin
                    // One cycle for the synchronous memory read.
                    tmr_carrega = 1'b1;
                    tmr_valor   = CARGA_ON;
                    prox_estado = ACESO;
                end
                ACESO: begin
                    if (tmr_zero) begin
                        tmr_carrega = 1'b1;
                        tmr_valor   = CARGA_OFF;
                        prox_estado = APAGADO;
                    end else begin
                        tmr_habilita = 1'b1;
                    end
                end
                APAGADO: begin
                    if (tmr_zero) begin
                        // Compare before increment, so the address never wraps.
                        if (endereco == lim_r) begin
                            prox_estado = FIM;
                        end else begin
                            end_incrementa = 1'b1;
                            prox_estado    = CARREGA;
                        end
                    end else begin
                        tmr_habilita = 1'b1;
                    end
                end
                FIM: begin
                    end_limpa   = 1'b1;
                    prox_estado = OCIOSO;
                end
                default: begin
                    end_limpa   = 1'b1;
                    prox_estado = OCIOSO;
                end
            endcase
        end
    end

    // Address and latched last index; the address only moves on CARREGA entry.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            endereco <= '0;
            lim_r    <= '0;
        end else begin
            if (end_limpa) begin
                endereco <= '0;
            end else if (end_incrementa) begin
                endereco <= endereco + ADDR_W'(1);
            end
            if (lim_carrega) begin
                lim_r <= limite;
            end
        end
    end

    assign leds_en   = (estado == ACESO);
    assign ocupado   = (estado != OCIOSO);
    assign fim       = (estado == FIM);
    assign db_estado = estado;

endmodule

// File: tb/tb_controle_exibe_sequencia.sv
module tb_controle_exibe_sequencia;

    localparam int ADDR_W = 4;
    localparam int T_ON   = 3;
    localparam int T_OFF  = 2;
    localparam int P      = 1 + T_ON + T_OFF;

    logic              clock;
    logic              reset;
    logic              iniciar;
    logic [ADDR_W-1:0] limite;
    logic              abortar;
    logic [ADDR_W-1:0] endereco;
    logic              leds_en;
    logic              ocupado;
    logic              fim;
    logic [3:0]        db_estado;

    int erros  = 0;
    int checks = 0;

    controle_exibe_sequencia #(
        .ADDR_W (ADDR_W),
        .T_ON   (T_ON),
        .T_OFF  (T_OFF)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .iniciar   (iniciar),
        .limite    (limite),
        .abortar   (abortar),
        .endereco  (endereco),
        .leds_en   (leds_en),
        .ocupado   (ocupado),
        .fim       (fim),
        .db_estado (db_estado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Expected state code and address in cycle k+j for n elements (iniciar sampled at edge k).
    function automatic void modelo(input int n, input int j, output int est, output int ende);
        int e, o;
        if (j >= 1 && j <= n * P) begin
            e = (j - 1) / P;
            o = (j - 1) % P;
            est  = (o == 0) ? 1 : ((o <= T_ON) ? 2 : 3);
            ende = e;
        end else if (j == n * P + 1) begin
            est  = 4;
            ende = n - 1;
        end else begin
            est  = 0;
            ende = 0;
        end
    endfunction

    // Drive iniciar before edge k; returns just after edge k.
    task automatic dispara(input int lim);
        @(negedge clock);
        limite  = ADDR_W'(lim);
        iniciar = 1'b1;
        @(posedge clock);
    endtask

    task automatic test_reset;
        reset = 1'b0; iniciar = 1'b0; abortar = 1'b0; limite = '0;
        #12;
        checks++;
        if ({endereco, leds_en, ocupado, fim, db_estado} !== '0) begin
            erros++;
            $display("FAIL reset_inicial: got end=%0d leds=%b ocup=%b fim=%b est=%0d, want all 0",
                     endereco, leds_en, ocupado, fim, db_estado);
        end
        @(negedge clock);
        reset = 1'b1;
        // Start, get into ACESO, then drop reset asynchronously mid-cycle.
        dispara(0);
        @(negedge clock); iniciar = 1'b0;
        @(negedge clock);
        checks++;
        if (leds_en !== 1'b1 || db_estado !== 4'd2) begin
            erros++;
            $display("FAIL reset_pre_aceso: got leds=%b est=%0d, want 1/2", leds_en, db_estado);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({endereco, leds_en, ocupado, fim, db_estado} !== '0) begin
            erros++;
            $display("FAIL reset_assincrono: got end=%0d leds=%b ocup=%b fim=%b est=%0d, want all 0",
                     endereco, leds_en, ocupado, fim, db_estado);
        end
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            checks++;
            if (db_estado !== 4'd0 || ocupado !== 1'b0) begin
                erros++;
                $display("FAIL reset_liberado[%0d]: got est=%0d ocup=%b, want 0/0", i, db_estado, ocupado);
            end
        end
    endtask

    // Cycle-by-cycle comparison of a playback; optional limite change at cycle mudar_em.
    task automatic test_sequencia(input string nome, input int lim, input int mudar_em, input int novo_lim);
        int est, ende, n_fim, n_leds;
        n_fim = 0; n_leds = 0;
        dispara(lim);
        for (int j = 1; j <= (lim + 1) * P + 3; j++) begin
            @(negedge clock);
            iniciar = 1'b0;
            modelo(lim + 1, j, est, ende);
            checks++;
            if (db_estado !== 4'(est) || endereco !== ADDR_W'(ende) || leds_en !== (est == 2) ||
                fim !== (est == 4) || ocupado !== (est != 0)) begin
                erros++;
                $display("FAIL %s ciclo k+%0d: got est=%0d end=%0d leds=%b fim=%b ocup=%b, want est=%0d end=%0d",
                         nome, j, db_estado, endereco, leds_en, fim, ocupado, est, ende);
            end
            if (fim === 1'b1) n_fim++;
            if (leds_en === 1'b1) n_leds++;
            if (j == mudar_em) limite = ADDR_W'(novo_lim);
        end
        checks++;
        if (n_fim != 1 || n_leds != (lim + 1) * T_ON) begin
            erros++;
            $display("FAIL %s contagens: got fim=%0d leds=%0d, want 1/%0d", nome, n_fim, n_leds, (lim + 1) * T_ON);
        end
    endtask

    task automatic test_abortar;
        int n_fim;
        n_fim = 0;
        dispara(3);
        // Second APAGADO covers cycles k+11..k+12; abort is sampled at edge k+11.
        for (int j = 1; j <= 11; j++) begin
            @(negedge clock);
            iniciar = 1'b0;
            if (fim === 1'b1) n_fim++;
        end
        checks++;
        if (db_estado !== 4'd3 || endereco !== 4'd1) begin
            erros++;
            $display("FAIL abortar_pre: got est=%0d end=%0d, want 3/1", db_estado, endereco);
        end
        abortar = 1'b1;
        @(negedge clock);
        abortar = 1'b0;
        checks++;
        if (db_estado !== 4'd0 || endereco !== 4'd0 || ocupado !== 1'b0 || fim !== 1'b0) begin
            erros++;
            $display("FAIL abortar_pos: got est=%0d end=%0d ocup=%b fim=%b, want 0/0/0/0",
                     db_estado, endereco, ocupado, fim);
        end
        for (int j = 0; j < 10; j++) begin
            @(negedge clock);
            if (fim === 1'b1) n_fim++;
        end
        checks++;
        if (n_fim != 0 || db_estado !== 4'd0) begin
            erros++;
            $display("FAIL abortar_sem_fim: got fim pulses=%0d est=%0d, want 0/0", n_fim, db_estado);
        end
        dispara(1);
        @(negedge clock); iniciar = 1'b0;
        checks++;
        if (db_estado !== 4'd1 || endereco !== 4'd0) begin
            erros++;
            $display("FAIL abortar_reinicio: got est=%0d end=%0d, want 1/0", db_estado, endereco);
        end
        abortar = 1'b1;
        @(negedge clock); abortar = 1'b0;
    endtask

    task automatic test_iniciar_ignorado;
        int est, ende;
        // iniciar together with abortar in OCIOSO: stay idle.
        @(negedge clock);
        iniciar = 1'b1; abortar = 1'b1; limite = 4'd2;
        @(negedge clock);
        iniciar = 1'b0; abortar = 1'b0;
        checks++;
        if (db_estado !== 4'd0 || ocupado !== 1'b0) begin
            erros++;
            $display("FAIL iniciar_abortar_ocioso: got est=%0d ocup=%b, want 0/0", db_estado, ocupado);
        end
        dispara(2);
        for (int j = 1; j <= 3 * P + 3; j++) begin
            @(negedge clock);
            iniciar = 1'b0;
            modelo(3, j, est, ende);
            checks++;
            if (db_estado !== 4'(est) || endereco !== ADDR_W'(ende) || fim !== (est == 4)) begin
                erros++;
                $display("FAIL reinicio_ocupado ciclo k+%0d: got est=%0d end=%0d fim=%b, want est=%0d end=%0d",
                         j, db_estado, endereco, fim, est, ende);
            end
            // Re-pulses while busy, including in the FIM cycle.
            if (j == 3 || j == 10 || j == 19) iniciar = 1'b1;
        end
    endtask

    initial begin
        test_reset();
        test_sequencia("lim0", 0, 0, 0);
        test_sequencia("lim2", 2, 4, 5);
        test_sequencia("lim15", 15, 0, 0);
        test_abortar();
        test_iniciar_ignorado();
        $display("Result: errors=%0d of %0d checks", erros, checks);
        $finish;
    end

endmodule
